// File: rtl/regmap_pckg.sv
// Register map constants and response encoding shared by the AXI4-Lite register slave
// and anything that decodes its map.
package regmap_pckg;

    localparam int C_CTRL_REG_IDX     = 0;
    localparam int C_STAT_REG_IDX     = 1;
    localparam int C_CFG_REG_IDX_BASE = 2;

    localparam int C_CTRL_REG_ADDR = 'h00;
    localparam int C_STAT_REG_ADDR = 'h04;
    localparam int C_CFG_REG_BASE  = 'h08;

    localparam int          C_CTRL_REG_START_LSB     = 0;
    localparam logic [31:0] C_CTRL_REG_START_MASK    = 32'h0000_0001;
    localparam int          C_CTRL_REG_SOFT_RST_LSB  = 1;
    localparam logic [31:0] C_CTRL_REG_SOFT_RST_MASK = 32'h0000_0002;

    localparam int          C_STAT_REG_TENS_TRANS_SEQ_BUSY_LSB  = 0;
    localparam logic [31:0] C_STAT_REG_TENS_TRANS_SEQ_BUSY_MASK = 32'h0000_0001;
    localparam int          C_STAT_REG_ERR_STICKY_LSB           = 1;
    localparam logic [31:0] C_STAT_REG_ERR_STICKY_MASK          = 32'h0000_0002;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axil_resp_e;

    function automatic logic idx_in_range(input int idx, input int cfg_num);
        return idx < (cfg_num + C_CFG_REG_IDX_BASE);
    endfunction

endpackage

// File: rtl/axil_regmap_slv.sv
// AXI4-Lite slave owning the accelerator register file: CTRL pulses, STAT (live busy,
// sticky error) and a byte-maskable bank of RW config registers.
module axil_regmap_slv
    import regmap_pckg::*;
#(
    parameter int C_S_AXI_DATA_WDT = 32,
    parameter int C_S_AXI_ADDR_WDT = 8,
    parameter int C_CFG_REG_NUM    = 62
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [C_S_AXI_ADDR_WDT-1:0]               s_axil_awaddr,
    input  logic                                      s_axil_awvalid,
    output logic                                      s_axil_awready,
    input  logic [C_S_AXI_DATA_WDT-1:0]               s_axil_wdata,
    input  logic [C_S_AXI_DATA_WDT/8-1:0]             s_axil_wstrb,
    input  logic                                      s_axil_wvalid,
    output logic                                      s_axil_wready,
    output logic [1:0]                                s_axil_bresp,
    output logic                                      s_axil_bvalid,
    input  logic                                      s_axil_bready,
    input  logic [C_S_AXI_ADDR_WDT-1:0]               s_axil_araddr,
    input  logic                                      s_axil_arvalid,
    output logic                                      s_axil_arready,
    output logic [C_S_AXI_DATA_WDT-1:0]               s_axil_rdata,
    output logic [1:0]                                s_axil_rresp,
    output logic                                      s_axil_rvalid,
    input  logic                                      s_axil_rready,
    input  logic                                      stat_seq_busy_i,
    input  logic                                      stat_err_i,
    output logic                                      ctrl_start_o,
    output logic                                      ctrl_soft_rst_o,
    output logic [C_CFG_REG_NUM*C_S_AXI_DATA_WDT-1:0] cfg_regs_o
);

    localparam int C_IDX_W  = C_S_AXI_ADDR_WDT - 2;
    localparam int C_STRB_W = C_S_AXI_DATA_WDT / 8;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    wr_state_e                   r_wr_state, w_wr_state_nxt;
    rd_state_e                   r_rd_state, w_rd_state_nxt;

    logic                        r_awready, r_wready, r_bvalid;
    logic                        r_aw_got, r_w_got;
    logic [C_IDX_W-1:0]          r_aw_idx;
    logic [C_S_AXI_DATA_WDT-1:0] r_wdata;
    logic [C_STRB_W-1:0]         r_wstrb;
    axil_resp_e                  r_bresp;

    logic                        r_arready, r_rvalid;
    logic [C_S_AXI_DATA_WDT-1:0] r_rdata;
    axil_resp_e                  r_rresp;

    logic [C_S_AXI_DATA_WDT-1:0] r_cfg [C_CFG_REG_NUM];
    logic                        r_err_sticky;
    logic                        r_start, r_soft_rst;

    logic                        w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit;
    logic                        w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
    logic                        w_aw_got_nxt, w_w_got_nxt;
    logic [C_IDX_W-1:0]          w_wr_idx;
    logic [C_S_AXI_DATA_WDT-1:0] w_wr_data;
    logic [C_STRB_W-1:0]         w_wr_strb;
    logic                        w_wr_in_range, w_wr_is_ctrl, w_wr_is_stat, w_err_clr;

    logic                        w_ar_hs, w_arready_nxt, w_rvalid_nxt;
    logic [C_IDX_W-1:0]          w_rd_idx;
    logic [C_S_AXI_DATA_WDT-1:0] w_rd_data;
    axil_resp_e                  w_rd_resp;
    logic                        w_unused_ok;

    assign w_unused_ok = &{1'b0, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // An address or data beat latched earlier takes precedence over the live bus.
    assign w_aw_hs   = s_axil_awvalid && r_awready;
    assign w_w_hs    = s_axil_wvalid && r_wready;
    assign w_aw_have = r_aw_got || w_aw_hs;
    assign w_w_have  = r_w_got || w_w_hs;
    assign w_wr_idx  = r_aw_got ? r_aw_idx : s_axil_awaddr[C_S_AXI_ADDR_WDT-1:2];
    assign w_wr_data = r_w_got ? r_wdata : s_axil_wdata;
    assign w_wr_strb = r_w_got ? r_wstrb : s_axil_wstrb;

    assign w_wr_in_range = idx_in_range(int'(w_wr_idx), C_CFG_REG_NUM);
    assign w_wr_is_ctrl  = int'(w_wr_idx) == C_CTRL_REG_IDX;
    assign w_wr_is_stat  = int'(w_wr_idx) == C_STAT_REG_IDX;
    assign w_err_clr     = w_commit && w_wr_is_stat && w_wr_strb[0]
                           && w_wr_data[C_STAT_REG_ERR_STICKY_LSB];

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_commit       = 1'b0;
        w_awready_nxt  = r_awready;
        w_wready_nxt   = r_wready;
        w_aw_got_nxt   = r_aw_got;
        w_w_got_nxt    = r_w_got;
        w_bvalid_nxt   = r_bvalid;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_have && w_w_have) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = WR_RESP;
                    w_awready_nxt  = 1'b0;
                    w_wready_nxt   = 1'b0;
                    w_aw_got_nxt   = 1'b0;
                    w_w_got_nxt    = 1'b0;
                    w_bvalid_nxt   = 1'b1;
                end else begin
                    w_awready_nxt  = !w_aw_have;
                    w_wready_nxt   = !w_w_have;
                    w_aw_got_nxt   = w_aw_have;
                    w_w_got_nxt    = w_w_have;
                end
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    w_wr_state_nxt = WR_IDLE;
                    w_awready_nxt  = 1'b1;
                    w_wready_nxt   = 1'b1;
                    w_bvalid_nxt   = 1'b0;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_aw_got   <= w_aw_got_nxt;
            r_w_got    <= w_w_got_nxt;
            r_bvalid   <= w_bvalid_nxt;
            if (w_commit) r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) r_aw_idx <= s_axil_awaddr[C_S_AXI_ADDR_WDT-1:2];
        if (w_w_hs) begin
            r_wdata <= s_axil_wdata;
            r_wstrb <= s_axil_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < C_CFG_REG_NUM; k++) r_cfg[k] <= '0;
        end else if (w_commit) begin
            for (int k = 0; k < C_CFG_REG_NUM; k++) begin
                if (int'(w_wr_idx) == k + C_CFG_REG_IDX_BASE) begin
                    for (int b = 0; b < C_STRB_W; b++) begin
                        if (w_wr_strb[b]) r_cfg[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // An error event in the same cycle as a W1C clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_start      <= 1'b0;
            r_soft_rst   <= 1'b0;
        end else begin
            if (stat_err_i)     r_err_sticky <= 1'b1;
            else if (w_err_clr) r_err_sticky <= 1'b0;
            r_start    <= w_commit && w_wr_is_ctrl && w_wr_strb[0]
                          && w_wr_data[C_CTRL_REG_START_LSB];
            r_soft_rst <= w_commit && w_wr_is_ctrl && w_wr_strb[0]
                          && w_wr_data[C_CTRL_REG_SOFT_RST_LSB];
        end
    end

    assign w_ar_hs  = s_axil_arvalid && r_arready;
    assign w_rd_idx = s_axil_araddr[C_S_AXI_ADDR_WDT-1:2];

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (!idx_in_range(int'(w_rd_idx), C_CFG_REG_NUM)) begin
            w_rd_resp = RESP_SLVERR;
        end else if (int'(w_rd_idx) == C_STAT_REG_IDX) begin
            w_rd_data[C_STAT_REG_TENS_TRANS_SEQ_BUSY_LSB] = stat_seq_busy_i;
            w_rd_data[C_STAT_REG_ERR_STICKY_LSB]          = r_err_sticky;
        end else begin
            for (int k = 0; k < C_CFG_REG_NUM; k++) begin
                if (int'(w_rd_idx) == k + C_CFG_REG_IDX_BASE) w_rd_data = r_cfg[k];
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = r_arready;
        w_rvalid_nxt   = r_rvalid;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_DATA;
                    w_arready_nxt  = 1'b0;
                    w_rvalid_nxt   = 1'b1;
                end
            end
            RD_DATA: begin
                if (s_axil_rready) begin
                    w_rd_state_nxt = RD_IDLE;
                    w_arready_nxt  = 1'b1;
                    w_rvalid_nxt   = 1'b0;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    for (genvar k = 0; k < C_CFG_REG_NUM; k++) begin : g_cfg_out
        assign cfg_regs_o[k*C_S_AXI_DATA_WDT +: C_S_AXI_DATA_WDT] = r_cfg[k];
    end

    assign s_axil_awready  = r_awready;
    assign s_axil_wready   = r_wready;
    assign s_axil_bvalid   = r_bvalid;
    assign s_axil_bresp    = r_bresp;
    assign s_axil_arready  = r_arready;
    assign s_axil_rvalid   = r_rvalid;
    assign s_axil_rdata    = r_rdata;
    assign s_axil_rresp    = r_rresp;
    assign ctrl_start_o    = r_start;
    assign ctrl_soft_rst_o = r_soft_rst;

endmodule
